// File: rtl/alu_result_led_viewer_if.sv
// Board-side bundle for alu_result_led_viewer: capture strobe, clear, view switches
// and the registered LED/status outputs.
interface alu_result_led_viewer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int LED_W  = 7,
  parameter int SEL_W  = 5
);
  // alu_valid_in is a strobe with no backpressure: every cycle it is high, alu_result_in
  // is accepted (there is no ready); clear_in wins over a same-cycle alu_valid_in.
  logic [SEL_W+1:0]        switches;
  logic [DATA_W-1:0]       alu_result_in;
  logic                    alu_valid_in;
  logic                    clear_in;
  logic [LED_W-1:0]        leds;
  logic [$clog2(DEPTH):0]  count_out;
  logic                    overflow_out;

  modport master (
    output switches, alu_result_in, alu_valid_in, clear_in,
    input  leds, count_out, overflow_out
  );

  modport slave (
    input  switches, alu_result_in, alu_valid_in, clear_in,
    output leds, count_out, overflow_out
  );
endinterface

// File: rtl/alu_result_led_viewer.sv
// Circular capture buffer of ALU results with a switch-selected, registered LED view.
// Define LED_AUTOSCROLL_EN to make mode 11 an auto-scrolling view of the buffer.
module alu_result_led_viewer #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 64,
  parameter int LED_W      = 7,
  parameter int SEL_W      = 5,
  parameter int SCROLL_DIV = 50000000
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_result_led_viewer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] MODE_INDEX  = 2'b00;
  localparam logic [1:0] MODE_SLICE  = 2'b01;
  localparam logic [1:0] MODE_STATUS = 2'b10;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic [LED_W-1:0]  r_leds;

  logic [1:0]        w_mode;
  logic [SEL_W-1:0]  w_sel;
  logic              w_capture;
  logic              w_idx_hit;
  logic [AW-1:0]     w_idx_addr;
  logic [DATA_W-1:0] w_latest;
  logic [LED_W-1:0]  w_idx_leds;
  logic [LED_W-1:0]  w_slice_leds;
  logic [LED_W-1:0]  w_status_leds;
  logic [LED_W-1:0]  w_next_leds;

  // Logical index 0 is the oldest retained entry; wrap arithmetic is DEPTH-wide.
  function automatic logic [AW-1:0] phys_addr(input logic [AW-1:0] wp,
                                               input logic [CW-1:0] cnt,
                                               input logic [AW-1:0] idx);
    return wp - AW'(cnt) + idx;
  endfunction

  assign w_mode    = bus.switches[SEL_W+1:SEL_W];
  assign w_sel     = bus.switches[SEL_W-1:0];
  assign w_capture = rst && !bus.clear_in && bus.alu_valid_in;

  assign w_idx_hit    = 32'(w_sel) < 32'(r_count);
  assign w_idx_addr   = phys_addr(r_wr_ptr, r_count, AW'(w_sel));
  assign w_idx_leds   = w_idx_hit ? LED_W'(r_mem[w_idx_addr]) : '0;
  assign w_latest     = r_mem[r_wr_ptr - AW'(1)];
  assign w_slice_leds = (r_count == '0) ? '0
                      : LED_W'(w_latest >> (32'(w_sel) * LED_W));
  assign w_status_leds = {r_overflow, (LED_W-1)'(r_count)};

`ifdef LED_AUTOSCROLL_EN
  localparam int PW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(SCROLL_DIV - 1);

  logic [PW-1:0]     r_prescale;
  logic [AW-1:0]     r_scroll_idx;
  logic [1:0]        r_mode_q;
  logic              w_scroll_entry;
  logic [AW-1:0]     w_scroll_idx;
  logic [LED_W-1:0]  w_scroll_leds;

  // On the first mode-11 cycle the stale index is not shown; index 0 is used directly.
  assign w_scroll_entry = (r_mode_q != 2'b11);
  assign w_scroll_idx   = w_scroll_entry ? '0 : r_scroll_idx;
  assign w_scroll_leds  = (32'(w_scroll_idx) < 32'(r_count))
                        ? LED_W'(r_mem[phys_addr(r_wr_ptr, r_count, w_scroll_idx)]) : '0;

  always_ff @(posedge clk) begin
    r_mode_q <= !rst ? 2'b00 : w_mode;
    if (!rst || bus.clear_in || w_mode != 2'b11 || w_scroll_entry) begin
      r_prescale   <= '0;
      r_scroll_idx <= '0;
    end else if (32'(r_scroll_idx) >= 32'(r_count)) begin
      r_scroll_idx <= '0;
    end else if (r_prescale == PRESCALE_LAST) begin
      r_prescale   <= '0;
      r_scroll_idx <= (32'(r_scroll_idx) + 1 >= 32'(r_count)) ? '0 : r_scroll_idx + AW'(1);
    end else begin
      r_prescale <= r_prescale + PW'(1);
    end
  end
`endif

  always_comb begin
    w_next_leds = '0;
    case (w_mode)
      MODE_INDEX:  w_next_leds = w_idx_leds;
      MODE_SLICE:  w_next_leds = w_slice_leds;
      MODE_STATUS: w_next_leds = w_status_leds;
`ifdef LED_AUTOSCROLL_EN
      default:     w_next_leds = w_scroll_leds;
`else
      default:     w_next_leds = w_idx_leds;
`endif
    endcase
  end

  // Storage is deliberately left out of reset and clear.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem[r_wr_ptr] <= bus.alu_result_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || bus.clear_in) begin
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_leds     <= '0;
    end else begin
      r_leds <= w_next_leds;
      if (bus.alu_valid_in) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_count == FULL) begin
          r_overflow <= 1'b1;
        end else begin
          r_count <= r_count + CW'(1);
        end
      end
    end
  end

  assign bus.leds         = r_leds;
  assign bus.count_out    = r_count;
  assign bus.overflow_out = r_overflow;
endmodule

// File: doc/alu_result_led_viewer.md
Name: alu_result_led_viewer

Overview:
- Parametrised successor to the single-mode ALU-result LED logger.
- Captures ALU results into a circular buffer of DEPTH entries and tracks fill count and overflow.
- Drives board LEDs from a registered view selected by switches: indexed entry, bit-slice of the latest entry, status, or optional auto-scroll.
- Sits between the core's ALU writeback (alu_valid_in) and the board LED pins.

Parameters:
- DATA_W, 32, width of captured ALU result.
- DEPTH, 64, buffer entries; power of 2, min 2.
- LED_W, 7, number of LEDs.
- SEL_W, 5, index/slice field width in switches.
- SCROLL_DIV, 50000000, clock cycles per auto-scroll step; min 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low (rst=0 resets on the clk rising edge).
- switches  in  SEL_W+2  [SEL_W+1:SEL_W]=mode, [SEL_W-1:0]=sel.
- alu_result_in  in  DATA_W  result to capture.
- alu_valid_in  in  1  capture strobe, one entry per cycle high.
- clear_in  in  1  synchronous buffer clear.
- leds  out  LED_W  registered LED drive.
- count_out  out  $clog2(DEPTH)+1  entries held, 0..DEPTH.
- overflow_out  out  1  sticky; an entry was overwritten.

Behaviour:
- Reset (rst=0): wr_ptr=0, count=0, overflow_out=0, leds=0, scroll state=0. Storage array is not reset.
- Capture: valid=1 writes mem[wr_ptr], then wr_ptr+1 mod DEPTH.
  - count increments, saturating at DEPTH.
  - Valid while count==DEPTH overwrites the oldest entry and sets overflow_out.
- clear_in=1: same effect as reset except the storage array. Clear has priority over a same-cycle valid; that valid is dropped.
- Logical index: idx 0 = oldest retained entry. Physical address = (wr_ptr - count + idx) mod DEPTH, using DEPTH-wide wrap arithmetic.
- leds is registered with 1-cycle latency from switches and from buffer state.
  - A write in cycle N is visible on leds at the earliest in cycle N+2: read-before-write, then output register.
- mode 00, indexed: leds = entry[sel][LED_W-1:0].
  - sel >= count -> leds = 0.
  - sel >= DEPTH -> leds = 0.
- mode 01, slice: leds = (latest entry >> (sel*LED_W))[LED_W-1:0].
  - Bits at or above DATA_W read as 0.
  - count==0 -> leds = 0.
  - Latest entry = physical (wr_ptr-1) mod DEPTH.
- mode 10, status: leds = {overflow_out, count} zero-extended or truncated to LED_W; overflow_out is always the MSB (LED_W-1).
- mode 11: see Optional Feature.
- Mode or sel change: new view appears on the next cycle; no glitch state.
- Widths: all index arithmetic is modulo DEPTH; count_out never exceeds DEPTH.

Optional Feature:
- Macro LED_AUTOSCROLL_EN.
- Defined: mode 11 is auto-scroll.
  - Prescaler counts 0..SCROLL_DIV-1. On wrap, scroll_idx advances by 1, wrapping to 0 at count-1.
  - leds = entry[scroll_idx][LED_W-1:0]; count==0 -> leds = 0, scroll_idx held at 0.
  - Entering mode 11 from any other mode resets the prescaler and scroll_idx to 0.
  - Clear and reset also reset the prescaler and scroll_idx.
  - If count shrinks below scroll_idx+1 (clear), scroll_idx=0.
- Undefined: no prescaler or scroll logic; mode 11 behaves exactly as mode 00.

Test Plan:
- Bench config: DEPTH=8, LED_W=7, SEL_W=5, SCROLL_DIV=4.
- Reset: hold rst=0 for 2 cycles with valid=1 -> leds=0, count_out=0, overflow_out=0. No capture occurs.
- Fill/index: write 0x11,0x22,0x33, mode 00, sel=1 -> leds=0x22 two cycles after the last write. sel=3 -> leds=0, count_out=3.
- Wrap/overflow: write 10 values 0x01..0x0A, mode 00 -> sel=0 gives 0x03, sel=7 gives 0x0A; count_out=8, overflow_out=1.
- Slice: latest=0x12345678, mode 01 -> sel=0 gives 0x78, sel=1 gives 0x2C, sel=4 gives 0x01, sel=5 gives 0x00.
- Clear vs valid: clear_in=1 and valid=1 with 0x55 in the same cycle -> count_out=0, overflow_out=0. Mode 10 leds=0; mode 00 sel=0 leds=0.
- Autoscroll (macro on): entries 0x01,0x02,0x03, mode 11 -> leds step 0x01→0x02→0x03→0x01, one step every 4 cycles. Macro off: mode 11 sel=2 gives 0x03.
